// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared width, state type and line-alignment helper for imem_pipelined
// Contents:
//   WORD_W     width of one memory word
//   state_t    INIT (zero-fill in progress) / RUN (serving fetches and loads)
//   line_base  clears the in-line word bits of a word index
package imem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // line_words is a power of two, so aligning is a plain mask of the low bits.
    function automatic logic [WORD_W-3:0] line_base(input logic [WORD_W-3:0] idx,
                                                    input int               line_words);
        logic [WORD_W-3:0] mask;
        mask = (WORD_W-2)'(line_words - 1);
        return idx & ~mask;
    endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// rtl/imem_resp_pipe.sv - fixed-latency response shift register for imem_pipelined
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 synchronous clear of every stage
//   in_valid/addr/err/data  response captured at request acceptance
//   out_valid/addr/err/data response leaving the last stage
// Stage payloads are forced to zero whenever the stage is empty, so the outputs
// read as zero whenever out_valid is low without any extra masking.
module imem_resp_pipe
    import imem_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_addr,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_addr,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;
    logic [WORD_W-1:0]  addr_q [LATENCY];
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_valid & in_err;
            addr_q[0]  <= in_valid ? in_addr : '0;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                addr_q[i]  <= addr_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_addr  = addr_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/imem_pipelined.sv
// rtl/imem_pipelined.sv - instruction memory with request/response fetch, line reads and a load port
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   init_done                        high once the post-reset zero-fill has finished
//   req_valid, req_ready, req_addr   fetch request (byte address)
//   flush                            kills every fetch still in flight
//   resp_valid, resp_addr, resp_err, resp_data  in-order response, single-cycle pulse
//   ld_en, ld_addr, ld_data          word write port (RUN state only)
module imem_pipelined
    import imem_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int LINE_WORDS = 1,
    parameter int LATENCY    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         init_done,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [WORD_W-1:0]            req_addr,
    input  logic                         flush,
    output logic                         resp_valid,
    output logic [WORD_W-1:0]            resp_addr,
    output logic [WORD_W*LINE_WORDS-1:0] resp_data,
    output logic                         resp_err,
    input  logic                         ld_en,
    input  logic [WORD_W-1:0]            ld_addr,
    input  logic [WORD_W-1:0]            ld_data
);

    localparam int AW     = $clog2(MEM_DEPTH);
    localparam int DATA_W = WORD_W * LINE_WORDS;

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    logic [WORD_W-3:0] req_idx;
    logic [WORD_W-3:0] req_base;
    logic              req_err;
    logic              req_accept;
    logic [DATA_W-1:0] rd_data;
    logic              ld_in_range;
    logic              unused_ld_low;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (state == INIT && cnt == AW'(MEM_DEPTH - 1)) begin
            state_next = RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    // The single write port is shared: zero-fill owns it in INIT, the load port in RUN.
    always_comb begin
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == INIT) begin
            mem_we    = !reset;
            mem_waddr = cnt;
        end else begin
            req_ready = !ld_en && !flush;
            if (ld_en && ld_in_range && !reset) begin
                mem_we    = 1'b1;
                mem_waddr = ld_addr[AW+1:2];
                mem_wdata = ld_data;
            end
        end
    end

    // Init counter walks the array once; it wraps harmlessly after the last write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // init_done trails the move to RUN by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_done <= 1'b0;
        end else begin
            init_done <= (state == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- load port address check ----------------
    assign ld_in_range   = ({2'b00, ld_addr[WORD_W-1:2]} < 32'(MEM_DEPTH));
    assign unused_ld_low = ^ld_addr[1:0];

    // ---------------- fetch address check and line read ----------------
    assign req_idx    = req_addr[WORD_W-1:2];
    assign req_base   = line_base(req_idx, LINE_WORDS);
    assign req_err    = (req_addr[1:0] != 2'b00) || ({2'b00, req_idx} >= 32'(MEM_DEPTH));
    assign req_accept = req_valid && req_ready;

    always_comb begin
        rd_data = '0;
        if (!req_err) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                rd_data[k*WORD_W +: WORD_W] = mem[req_base[AW-1:0] + AW'(k)];
            end
        end
    end

    imem_resp_pipe #(
        .LATENCY (LATENCY),
        .DATA_W  (DATA_W)
    ) u_resp_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (req_accept),
        .in_addr   ({req_base, 2'b00}),
        .in_err    (req_err),
        .in_data   (rd_data),
        .out_valid (resp_valid),
        .out_addr  (resp_addr),
        .out_err   (resp_err),
        .out_data  (resp_data)
    );

endmodule

// File: tb/tb_imem_pipelined.sv
// tb/tb_imem_pipelined.sv - self-checking bench for imem_pipelined (two configurations)
module tb_imem_pipelined;

    localparam int A_DEPTH = 32;
    localparam int A_LW    = 1;
    localparam int A_LAT   = 1;
    localparam int B_DEPTH = 64;
    localparam int B_LW    = 4;
    localparam int B_LAT   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        a_init_done, a_req_valid, a_req_ready, a_flush, a_resp_valid, a_resp_err, a_ld_en;
    logic [31:0] a_req_addr, a_resp_addr, a_ld_addr, a_ld_data;
    logic [31:0] a_resp_data;

    logic         b_init_done, b_req_valid, b_req_ready, b_flush, b_resp_valid, b_resp_err, b_ld_en;
    logic [31:0]  b_req_addr, b_resp_addr, b_ld_addr, b_ld_data;
    logic [127:0] b_resp_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mdl_b [B_DEPTH];

    typedef struct {
        int           vis;
        logic [31:0]  addr;
        logic         err;
        logic [127:0] data;
    } exp_t;

    always #5 clk = ~clk;

    imem_pipelined #(.MEM_DEPTH(A_DEPTH), .LINE_WORDS(A_LW), .LATENCY(A_LAT)) dut_a (
        .clk(clk), .reset(reset), .init_done(a_init_done),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .flush(a_flush), .resp_valid(a_resp_valid), .resp_addr(a_resp_addr),
        .resp_data(a_resp_data), .resp_err(a_resp_err),
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
    );

    imem_pipelined #(.MEM_DEPTH(B_DEPTH), .LINE_WORDS(B_LW), .LATENCY(B_LAT)) dut_b (
        .clk(clk), .reset(reset), .init_done(b_init_done),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .flush(b_flush), .resp_valid(b_resp_valid), .resp_addr(b_resp_addr),
        .resp_data(b_resp_data), .resp_err(b_resp_err),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req_valid = 0; a_req_addr = 0; a_flush = 0; a_ld_en = 0; a_ld_addr = 0; a_ld_data = 0;
        b_req_valid = 0; b_req_addr = 0; b_flush = 0; b_ld_en = 0; b_ld_addr = 0; b_ld_data = 0;
    endtask

    // Expected line contents from the reference array; word w sits at bits [32w+31:32w].
    function automatic logic [127:0] b_line(input logic [31:0] addr);
        logic [127:0] d;
        int           w;
        d = '0;
        if (addr[1:0] != 2'b00 || addr >= 32'(4 * B_DEPTH)) return d;
        w = int'(addr >> 2) / B_LW * B_LW;
        for (int k = 0; k < B_LW; k++) d[k*32 +: 32] = mdl_b[w + k];
        return d;
    endfunction

    function automatic logic [31:0] b_line_addr(input logic [31:0] addr);
        return (addr / 32'(4 * B_LW)) * 32'(4 * B_LW);
    endfunction

    function automatic logic [31:0] rand_addr();
        int m;
        m = $urandom_range(0, 9);
        if (m < 8) return 32'($urandom_range(0, B_DEPTH - 1)) << 2;
        if (m == 8) return (32'($urandom_range(0, B_DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        return 32'(4 * B_DEPTH) + 32'($urandom_range(0, 4095));
    endfunction

    task automatic b_load(input logic [31:0] addr, input logic [31:0] data);
        b_ld_en = 1; b_ld_addr = addr; b_ld_data = data;
        tick();
        b_ld_en = 0;
        if (addr < 32'(4 * B_DEPTH)) mdl_b[int'(addr >> 2)] = data;
    endtask

    // Issues one fetch and returns the first response seen, or lat=-1 after the budget.
    task automatic b_fetch(input logic [31:0] addr, output int lat, output logic [31:0] raddr,
                           output logic rerr, output logic [127:0] rdata);
        b_req_valid = 1; b_req_addr = addr; lat = -1; raddr = 'x; rerr = 'x; rdata = 'x;
        for (int c = 1; c <= 10; c++) begin
            tick();
            b_req_valid = 0;
            if (b_resp_valid === 1'b1) begin
                lat = c; raddr = b_resp_addr; rerr = b_resp_err; rdata = b_resp_data;
                break;
            end
        end
    endtask

    task automatic a_fetch(input logic [31:0] addr, output int lat, output logic [31:0] raddr,
                           output logic rerr, output logic [31:0] rdata);
        a_req_valid = 1; a_req_addr = addr; lat = -1; raddr = 'x; rerr = 'x; rdata = 'x;
        for (int c = 1; c <= 10; c++) begin
            tick();
            a_req_valid = 0;
            if (a_resp_valid === 1'b1) begin
                lat = c; raddr = a_resp_addr; rerr = a_resp_err; rdata = a_resp_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int rise_a, rise_b, lat;
        bit ready_bad;
        logic [31:0] ra;
        logic re;
        logic [127:0] rd;
        idle_inputs();
        reset = 1;
        tick();
        tests++;
        if ({a_init_done, a_req_ready, a_resp_valid, a_resp_err, a_resp_addr, a_resp_data} !== '0) begin
            fails++; $display("FAIL reset_a_outputs: got %b/%b/%b/%b/%h/%h required all zero",
                              a_init_done, a_req_ready, a_resp_valid, a_resp_err, a_resp_addr, a_resp_data);
        end
        tests++;
        if ({b_init_done, b_req_ready, b_resp_valid, b_resp_err, b_resp_addr, b_resp_data} !== '0) begin
            fails++; $display("FAIL reset_b_outputs: got %b/%b/%b/%b/%h/%h required all zero",
                              b_init_done, b_req_ready, b_resp_valid, b_resp_err, b_resp_addr, b_resp_data);
        end
        reset = 0;
        for (int w = 0; w < B_DEPTH; w++) mdl_b[w] = '0;
        rise_a = -1; rise_b = -1; ready_bad = 0;
        // A load held through INIT must be ignored.
        b_ld_en = 1; b_ld_addr = 32'h10; b_ld_data = 32'hDEADBEEF;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (a_init_done === 1'b1 && rise_a < 0) rise_a = i;
            if (b_init_done === 1'b1 && rise_b < 0) rise_b = i;
            if (i < A_DEPTH && a_req_ready !== 1'b0) ready_bad = 1;
            if (i == B_DEPTH) b_ld_en = 0;
        end
        tests++;
        if (rise_a != A_DEPTH + 1) begin
            fails++; $display("FAIL init_done_a_rise: got cycle %0d required %0d", rise_a, A_DEPTH + 1);
        end
        tests++;
        if (rise_b != B_DEPTH + 1) begin
            fails++; $display("FAIL init_done_b_rise: got cycle %0d required %0d", rise_b, B_DEPTH + 1);
        end
        tests++;
        if (ready_bad) begin
            fails++; $display("FAIL ready_during_init: got req_ready=1 required 0");
        end
        tests++;
        if (a_req_ready !== 1'b1) begin
            fails++; $display("FAIL ready_after_init: got %b required 1", a_req_ready);
        end
        b_fetch(32'h10, lat, ra, re, rd);
        tests++;
        if (lat != B_LAT || ra !== 32'h10 || re !== 1'b0 || rd !== 128'h0) begin
            fails++; $display("FAIL fetch_after_init: got lat=%0d addr=%h err=%b data=%h required lat=%0d addr=00000010 err=0 data=0",
                              lat, ra, re, rd, B_LAT);
        end
    endtask

    task automatic test_load_fetch();
        int lat;
        logic [31:0] ra, rd;
        logic re;
        a_ld_en = 1; a_ld_addr = 32'h0; a_ld_data = 32'h00500093;
        #1;
        tests++;
        if (a_req_ready !== 1'b0) begin
            fails++; $display("FAIL ready_during_load: got %b required 0", a_req_ready);
        end
        tick();
        a_ld_en = 0;
        a_fetch(32'h0, lat, ra, re, rd);
        tests++;
        if (lat != A_LAT || ra !== 32'h0 || re !== 1'b0 || rd !== 32'h00500093) begin
            fails++; $display("FAIL load_then_fetch: got lat=%0d addr=%h err=%b data=%h required lat=1 addr=0 err=0 data=00500093",
                              lat, ra, re, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic         v1, v2, v3, early;
        logic [31:0]  a1, a2;
        logic [127:0] d1, d2, d3;
        for (int w = 0; w < 8; w++) b_load(32'(4 * w), 32'hA0 + 32'(w));
        b_req_valid = 1; b_req_addr = 32'h4;
        tick();
        b_req_addr = 32'h10;
        tick();
        b_req_valid = 0;
        early = b_resp_valid;
        tick(); v1 = b_resp_valid; a1 = b_resp_addr; d1 = b_resp_data;
        tick(); v2 = b_resp_valid; a2 = b_resp_addr; d2 = b_resp_data;
        tick(); v3 = b_resp_valid; d3 = b_resp_data;
        tests++;
        if (early !== 1'b0) begin
            fails++; $display("FAIL b2b_no_early_resp: got %b required 0", early);
        end
        tests++;
        if (v1 !== 1'b1 || a1 !== 32'h0 || d1 !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            fails++; $display("FAIL b2b_first: got v=%b addr=%h data=%h required v=1 addr=0 data=A3..A0", v1, a1, d1);
        end
        tests++;
        if (v2 !== 1'b1 || a2 !== 32'h10 || d2 !== {32'hA7, 32'hA6, 32'hA5, 32'hA4}) begin
            fails++; $display("FAIL b2b_second: got v=%b addr=%h data=%h required v=1 addr=10 data=A7..A4", v2, a2, d2);
        end
        tests++;
        if (v3 !== 1'b0 || d3 !== 128'h0) begin
            fails++; $display("FAIL b2b_idle_zero: got v=%b data=%h required v=0 data=0", v3, d3);
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [31:0] ra, rda;
        logic re;
        logic [127:0] rd;
        b_fetch(32'h6, lat, ra, re, rd);
        tests++;
        if (lat != B_LAT || re !== 1'b1 || rd !== 128'h0 || ra !== 32'h0) begin
            fails++; $display("FAIL err_misaligned: got lat=%0d err=%b addr=%h data=%h required lat=3 err=1 addr=0 data=0", lat, re, ra, rd);
        end
        b_fetch(32'(4 * B_DEPTH), lat, ra, re, rd);
        tests++;
        if (lat != B_LAT || re !== 1'b1 || rd !== 128'h0) begin
            fails++; $display("FAIL err_out_of_range: got lat=%0d err=%b data=%h required lat=3 err=1 data=0", lat, re, rd);
        end
        b_load(32'(4 * B_DEPTH), 32'h0BAD0BAD);
        b_fetch(32'h0, lat, ra, re, rd);
        tests++;
        if (lat != B_LAT || re !== 1'b0 || rd !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            fails++; $display("FAIL ld_out_of_range_dropped: got err=%b data=%h required err=0 data=A3..A0", re, rd);
        end
        a_ld_en = 1; a_ld_addr = 32'(4 * A_DEPTH); a_ld_data = 32'hFFFFFFFF;
        tick();
        a_ld_en = 0;
        a_fetch(32'h0, lat, ra, re, rda);
        tests++;
        if (lat != A_LAT || re !== 1'b0 || rda !== 32'h00500093) begin
            fails++; $display("FAIL a_ld_out_of_range_dropped: got err=%b data=%h required err=0 data=00500093", re, rda);
        end
        a_fetch(32'(4 * A_DEPTH), lat, ra, re, rda);
        tests++;
        if (lat != A_LAT || re !== 1'b1 || rda !== 32'h0) begin
            fails++; $display("FAIL a_err_out_of_range: got lat=%0d err=%b data=%h required lat=1 err=1 data=0", lat, re, rda);
        end
    endtask

    task automatic test_flush();
        int lat, pulses;
        logic [31:0] ra;
        logic re;
        logic [127:0] rd;
        b_req_valid = 1; b_req_addr = 32'h0;
        tick();
        b_req_addr = 32'h10;
        tick();
        b_req_addr = 32'h20;
        tick();
        // The oldest fetch is already on the outputs during the flush cycle.
        tests++;
        if (b_resp_valid !== 1'b1 || b_resp_addr !== 32'h0) begin
            fails++; $display("FAIL flush_cycle_resp: got v=%b addr=%h required v=1 addr=0", b_resp_valid, b_resp_addr);
        end
        b_req_addr = 32'h30; b_flush = 1;
        #1;
        tests++;
        if (b_req_ready !== 1'b0) begin
            fails++; $display("FAIL ready_during_flush: got %b required 0", b_req_ready);
        end
        tick();
        b_flush = 0; b_req_valid = 0; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (b_resp_valid === 1'b1) pulses++;
            tick();
        end
        tests++;
        if (pulses != 0) begin
            fails++; $display("FAIL flush_kills_inflight: got %0d responses required 0", pulses);
        end
        b_fetch(32'h20, lat, ra, re, rd);
        tests++;
        if (lat != B_LAT || ra !== 32'h20 || re !== 1'b0 || rd !== b_line(32'h20)) begin
            fails++; $display("FAIL fetch_after_flush: got lat=%0d addr=%h data=%h required lat=3 addr=20 data=%h",
                              lat, ra, rd, b_line(32'h20));
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t ent;
        bit ld, fl, rv;
        int e;
        logic         ev, eerr;
        logic [31:0]  ea;
        logic [127:0] ed;
        idle_inputs();
        repeat (5) tick();
        e = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ld = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            rv = ($urandom_range(0, 99) < 70);
            b_ld_en = ld; b_flush = fl; b_req_valid = rv; b_req_addr = rand_addr();
            b_ld_addr = ($urandom_range(0, 9) == 0) ? 32'(4 * B_DEPTH) + 32'($urandom_range(0, 255))
                                                    : (32'($urandom_range(0, B_DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
            b_ld_data = $urandom();
            #1;
            tests++;
            if (b_req_ready !== (!ld && !fl)) begin
                fails++; $display("FAIL rand_ready cyc %0d: got %b required %b", cyc, b_req_ready, !ld && !fl);
            end
            e++;
            if (fl) while (q.size() > 0 && q[q.size()-1].vis >= e) void'(q.pop_back());
            if (rv && !ld && !fl) begin
                ent.vis  = e + B_LAT - 1;
                ent.addr = b_line_addr(b_req_addr);
                ent.err  = (b_req_addr[1:0] != 2'b00) || (b_req_addr >= 32'(4 * B_DEPTH));
                ent.data = b_line(b_req_addr);
                q.push_back(ent);
            end
            if (ld && b_ld_addr < 32'(4 * B_DEPTH)) mdl_b[int'(b_ld_addr >> 2)] = b_ld_data;
            tick();
            ev = 0; ea = '0; eerr = 0; ed = '0;
            if (q.size() > 0 && q[0].vis == e) begin
                ent = q.pop_front();
                ev = 1; ea = ent.addr; eerr = ent.err; ed = ent.data;
            end
            tests++;
            if ({b_resp_valid, b_resp_addr, b_resp_err, b_resp_data} !== {ev, ea, eerr, ed}) begin
                fails++; $display("FAIL rand_resp cyc %0d: got v=%b a=%h e=%b d=%h required v=%b a=%h e=%b d=%h",
                                  cyc, b_resp_valid, b_resp_addr, b_resp_err, b_resp_data, ev, ea, eerr, ed);
            end
        end
        idle_inputs();
        repeat (5) tick();
    endtask

    task automatic test_reset_midrun();
        int pulses, lat;
        logic [31:0] ra;
        logic re;
        logic [127:0] rd;
        b_load(32'h40, 32'h12345678);
        b_req_valid = 1; b_req_addr = 32'h40;
        tick();
        b_req_addr = 32'h44;
        tick();
        b_req_valid = 0;
        reset = 1;
        pulses = 0;
        tick();
        tick();
        reset = 0;
        for (int w = 0; w < B_DEPTH; w++) mdl_b[w] = '0;
        for (int i = 0; i < 80; i++) begin
            if (b_resp_valid === 1'b1) pulses++;
            tick();
        end
        tests++;
        if (pulses != 0) begin
            fails++; $display("FAIL reset_kills_inflight: got %0d responses required 0", pulses);
        end
        tests++;
        if (b_init_done !== 1'b1) begin
            fails++; $display("FAIL reinit_done: got %b required 1", b_init_done);
        end
        b_fetch(32'h40, lat, ra, re, rd);
        tests++;
        if (lat != B_LAT || re !== 1'b0 || rd !== 128'h0) begin
            fails++; $display("FAIL data_cleared_by_reinit: got lat=%0d err=%b data=%h required lat=3 err=0 data=0", lat, re, rd);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_errors();
        test_flush();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
